// File: rtl/mcntrl_seq_pkg.sv
// Shared definitions for the memory-channel page sequencer:
// FSM states, command register addresses and mode-register bit positions.
package mcntrl_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_GAP   = 2'd3
    } seq_state_e;

    localparam logic [3:0] SEQ_ADDR_MODE    = 4'h0;
    localparam logic [3:0] SEQ_ADDR_NFRAMES = 4'h1;

    localparam int MODE_RUN   = 0;
    localparam int MODE_CLEAR = 1;
    localparam int MODE_STOP  = 2;

endpackage

// File: rtl/mcntrl_page_credit.sv
// Buffer occupancy and page-release bookkeeping for one channel: tracks filled
// pages, paces next_page from consumer releases and raises sticky over/underrun.
module mcntrl_page_credit #(
    parameter int NUM_PAGES = 4
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       page_ready,
    input  logic       page_consumed,
    output logic       next_page,
    output logic       suspend,
    output logic [2:0] buffered,
    output logic       overrun,
    output logic       underrun
);

    localparam logic [2:0] FULL = 3'(NUM_PAGES);

    logic [2:0] pend_rel;
    logic       emit;

    // A release is forwarded only if the previous cycle was not a pulse,
    // so consecutive pulses are always separated by one idle cycle.
    assign emit = (pend_rel != 3'd0) && !next_page;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            buffered  <= 3'd0;
            pend_rel  <= 3'd0;
            next_page <= 1'b0;
            suspend   <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            next_page <= emit;
            suspend   <= (buffered >= FULL);

            if (clear) begin
                overrun  <= 1'b0;
                underrun <= 1'b0;
            end

            if (page_ready && !page_consumed) begin
                if (buffered == FULL) overrun <= 1'b1;
                else                  buffered <= buffered + 3'd1;
            end else if (page_consumed && !page_ready) begin
                if (buffered == 3'd0) underrun <= 1'b1;
                else                  buffered <= buffered - 3'd1;
            end

            if (page_consumed && !emit) begin
                if (pend_rel != FULL) pend_rel <= pend_rel + 3'd1;
            end else if (!page_consumed && emit) begin
                pend_rel <= pend_rel - 3'd1;
            end
        end
    end

endmodule

// File: rtl/mcntrl_page_sequencer.sv
// Autonomous frame/page sequencer for one memory channel: starts N frames (or runs
// continuously), spaces them by FRAME_GAP cycles and exports a status payload.
module mcntrl_page_sequencer
    import mcntrl_seq_pkg::*;
#(
    parameter int         FRAME_HEIGHT_BITS = 16,
    parameter int         NUM_PAGES         = 4,
    parameter int         PAGE_BITS         = 4,
    parameter int         FRAME_GAP         = 8,
    parameter logic [3:0] SEQ_MODE_ADDR     = SEQ_ADDR_MODE,
    parameter logic [3:0] SEQ_NFRAMES_ADDR  = SEQ_ADDR_NFRAMES
) (
    input  logic                                   mclk,
    input  logic                                   rst_n,
    input  logic                                   cmd_we,
    input  logic [3:0]                             cmd_a,
    input  logic [7:0]                             cmd_data,
    input  logic                                   page_consumed,
    output logic                                   frame_start,
    output logic                                   next_page,
    output logic                                   suspend,
    input  logic                                   page_ready,
    input  logic                                   frame_done,
    input  logic [FRAME_HEIGHT_BITS-1:0]           line_unfinished,
    output logic [FRAME_HEIGHT_BITS+PAGE_BITS+5:0] status
);

    localparam logic [7:0] GAP_LOAD = 8'(FRAME_GAP - 1);

    seq_state_e           state, state_nxt;
    logic [7:0]           nframes, frames_left, gap_cnt;
    logic [PAGE_BITS-1:0] page_cnt;
    logic                 stop_pend;
    logic                 mode_we, run_cmd, halt_cmd, stop_set, clear_cmd, last_frame;
    logic [2:0]           buffered;
    logic                 overrun, underrun;

    assign mode_we    = cmd_we && (cmd_a == SEQ_MODE_ADDR);
    assign run_cmd    = mode_we && cmd_data[MODE_RUN];
    assign halt_cmd   = mode_we && !cmd_data[MODE_RUN];
    assign stop_set   = mode_we && (cmd_data[MODE_STOP] || !cmd_data[MODE_RUN]);
    assign clear_cmd  = mode_we && cmd_data[MODE_CLEAR];
    // frames_left of 0 means continuous: it is never decremented to reach 0.
    assign last_frame = stop_pend || stop_set || (frames_left == 8'd1);

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE:  if (run_cmd) state_nxt = SEQ_START;
            SEQ_START: state_nxt = halt_cmd ? SEQ_IDLE : SEQ_RUN;
            SEQ_RUN: begin
                if (frame_done) begin
                    if (last_frame)         state_nxt = SEQ_IDLE;
                    else if (FRAME_GAP > 1) state_nxt = SEQ_GAP;
                    else                    state_nxt = SEQ_START;
                end
            end
            SEQ_GAP: begin
                if (stop_pend || stop_set) state_nxt = SEQ_IDLE;
                else if (gap_cnt <= 8'd1)  state_nxt = SEQ_START;
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEQ_IDLE;
            frame_start <= 1'b0;
            nframes     <= 8'd0;
            frames_left <= 8'd0;
            gap_cnt     <= 8'd0;
            page_cnt    <= '0;
            stop_pend   <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_start <= (state == SEQ_START) && (state_nxt == SEQ_RUN);

            if (cmd_we && (cmd_a == SEQ_NFRAMES_ADDR)) nframes <= cmd_data;

            if (state == SEQ_IDLE && run_cmd)
                frames_left <= nframes;
            else if (state == SEQ_RUN && frame_done && state_nxt != SEQ_IDLE && frames_left != 8'd0)
                frames_left <= frames_left - 8'd1;

            // The START cycle plus GAP_LOAD GAP cycles give FRAME_GAP idle cycles.
            if (state_nxt == SEQ_GAP && state != SEQ_GAP) gap_cnt <= GAP_LOAD;
            else if (state == SEQ_GAP)                    gap_cnt <= gap_cnt - 8'd1;

            if (clear_cmd || state == SEQ_START)  page_cnt <= '0;
            else if (state == SEQ_RUN && page_ready) page_cnt <= page_cnt + 1'b1;

            if (state_nxt == SEQ_IDLE) stop_pend <= 1'b0;
            else if (stop_set)         stop_pend <= 1'b1;
        end
    end

    mcntrl_page_credit #(
        .NUM_PAGES(NUM_PAGES)
    ) u_credit (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .clear        (clear_cmd),
        .page_ready   (page_ready),
        .page_consumed(page_consumed),
        .next_page    (next_page),
        .suspend      (suspend),
        .buffered     (buffered),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    assign status = {overrun, underrun, (state != SEQ_IDLE), buffered, page_cnt, line_unfinished};

endmodule

// File: doc/mcntrl_page_sequencer.md
Name: mcntrl_page_sequencer

Overview:
- Autonomous frame/page sequencer for one memory channel. Replaces host-driven frame_start/next_page pulses.
- Sits between the command deserializer (cmd_we/cmd_a/cmd_data) and a channel's control inputs.
- Starts N frames (or runs continuously) and converts buffer-consumer page releases into paced next_page pulses.
- Tracks buffer occupancy, drives suspend, and exports a status payload to the channel's status generator.

Parameters:
- FRAME_HEIGHT_BITS, 16, width of line_unfinished.
- NUM_PAGES, 4, buffer pages available to the channel (2..7).
- PAGE_BITS, 4, width of the per-frame page counter (wraps).
- FRAME_GAP, 8, idle mclk cycles between frame_done and the next frame_start (1..255).
- SEQ_MODE_ADDR, 'h0, cmd_a value for the mode register.
- SEQ_NFRAMES_ADDR, 'h1, cmd_a value for the frame-count register.

Ports:
- mclk  in  1  global clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_we  in  1  command write strobe, 1 cycle.
- cmd_a  in  4  command register address.
- cmd_data  in  8  command data.
- page_consumed  in  1  consumer released one buffer page (1-cycle pulse).
- frame_start  out  1  1-cycle pulse to channel.
- next_page  out  1  1-cycle pulse to channel.
- suspend  out  1  level to channel.
- page_ready  in  1  channel filled one page.
- frame_done  in  1  channel finished frame.
- line_unfinished  in  FRAME_HEIGHT_BITS  passthrough to status.
- status  out  FRAME_HEIGHT_BITS+PAGE_BITS+6  {overrun, underrun, busy, buffered[2:0], page_cnt, line_unfinished}.

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, all counters 0, sticky flags 0. nframes=0; in this state 0 means continuous.
- Command decode:
  - SEQ_MODE_ADDR: data[0]=run, data[1]=clear counters/sticky flags, data[2]=stop after current frame.
  - SEQ_NFRAMES_ADDR: nframes=data. Writes to nframes outside IDLE take effect at the next run command.
- FSM states:
  - IDLE: run=1 -> START; frames_left<=nframes.
  - START: frame_start=1 for exactly one cycle, page_cnt<=0 -> RUN. frame_start is registered and appears 2 cycles after the cmd_we of the run command.
  - RUN: on frame_done:
    - if stop pending, or frames_left==1 (and nframes!=0) -> IDLE.
    - else -> GAP; frames_left decrements unless continuous.
  - GAP: count FRAME_GAP cycles, then -> START.
  - run=0 command in any state != IDLE sets stop pending. RUN completes the frame; GAP/START go to IDLE immediately after the current cycle.
- busy=1 in START/RUN/GAP.
- page_cnt: +1 per page_ready in RUN, wraps at 2^PAGE_BITS. Cleared in START and by the clear command.
- buffered (0..NUM_PAGES): +1 on page_ready, -1 on page_consumed, unchanged if both occur in the same cycle.
  - page_ready while buffered==NUM_PAGES: saturate, set sticky overrun.
  - page_consumed while buffered==0: ignore, set sticky underrun.
- pend_rel (0..NUM_PAGES): +1 on page_consumed, -1 on each next_page emission, unchanged if both occur in the same cycle. Saturates at NUM_PAGES.
- next_page: registered pulse, emitted when pend_rel>0 and next_page was 0 in the previous cycle. Maximum rate is one pulse every 2 cycles.
  - Emitted regardless of FSM state, so releases after a stop still drain.
- suspend: registered, equal to (buffered>=NUM_PAGES). Updates 1 cycle after buffered changes.
- frame_done in IDLE/GAP/START: ignored.
- Reset mid-frame: everything returns to IDLE immediately; no frame_start or next_page is emitted until reset deasserts and a run command is received.
- status: combinational from registers and line_unfinished. Zero latency apart from the register update.

Decomposition:
- Shared package (mcntrl_seq_pkg): FSM state encoding (IDLE/START/RUN/GAP); SEQ_* command addresses; mode-bit indices (RUN, CLEAR, STOP).
- Natural sub-module: mcntrl_page_credit. It holds the buffered and pend_rel counters, the next_page pacing and the overrun/underrun flags.
- The FSM and frame counter stay in the top module.

Test Plan:
- Reset, write nframes=2, then run=1:
  - frame_start pulses 2 cycles after cmd_we.
  - frame_done -> 8 gap cycles -> second frame_start.
  - Second frame_done -> IDLE, busy=0.
- nframes=0, run=1, three frame_done: three subsequent frame_starts, each FRAME_GAP+1 cycles after its frame_done.
- Four page_ready with no consumption: buffered=4, suspend=1 one cycle later. Fifth page_ready -> overrun=1, buffered stays 4.
- Three page_consumed in consecutive cycles after buffered=4:
  - Exactly three next_page pulses, 2 cycles apart.
  - buffered=1, suspend=0.
- page_ready and page_consumed in the same cycle at buffered=2: buffered=2, pend_rel +1, one next_page pulse follows.
- rst_n low in RUN with pend_rel=2: outputs 0 immediately; after release, no next_page or frame_start until a new run command.
